// File: rtl/stage_sequencer_pkg.sv
// stage_sequencer_pkg: state and fault encodings shared by the stage sequencer files
package stage_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'd0,
        FLT_ILLEGAL = 2'd1,
        FLT_IMEM_TO = 2'd2,
        FLT_DMEM_TO = 2'd3
    } fault_t;

endpackage

// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: memory/decoder status in, stage strobes out
//   master: sequencer side (reads ready/decode flags, drives strobes)
//   slave : datapath side (drives ready/decode flags, reads strobes)
interface stage_sequencer_if;
    logic imem_ready;
    logic dmem_ready;
    logic is_mem_op;
    logic illegal_inst;
    logic en_if;
    logic en_id;
    logic en_ex;
    logic en_mem;
    logic en_wb;
    logic pc_we;

    modport master (
        input  imem_ready, dmem_ready, is_mem_op, illegal_inst,
        output en_if, en_id, en_ex, en_mem, en_wb, pc_we
    );

    modport slave (
        output imem_ready, dmem_ready, is_mem_op, illegal_inst,
        input  en_if, en_id, en_ex, en_mem, en_wb, pc_we
    );
endinterface

// File: rtl/stage_sequencer_wait_timer.sv
// stage_sequencer_wait_timer: wait-state counter flagging the last allowed wait cycle
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the counter (takes priority over cnt_en)
//   cnt_en   : advance the counter by one
//   expire   : counter has reached TIMEOUT_CYCLES-1
module stage_sequencer_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cnt_en,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : cnt_en ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign expire = cnt_q == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle IF/ID/EX/MEM/WB sequencer with strobes, timeouts, step and halt
//   clk, rst   : clock, synchronous active-high reset
//   run        : free-run while high
//   step_req   : start one instruction from IDLE
//   bus        : ready/decode flags in, stage strobes out
//   state      : current state encoding
//   halted     : sticky fault halt
//   fault_code : 0 none, 1 illegal, 2 imem timeout, 3 dmem timeout
//   retire_cnt : retired instructions, wrapping
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                step_req,
    stage_sequencer_if.master   bus,
    output logic [2:0]          state,
    output logic                halted,
    output logic [1:0]          fault_code,
    output logic [CNT_W-1:0]    retire_cnt
);
    state_t             state_q, state_d;
    fault_t             fault_q, fault_d;
    logic               step_q, step_d;
    logic [CNT_W-1:0]   retire_q, retire_d;
    logic               expire;

    // Any state change restarts the wait count, so each IF/MEM visit gets a full budget.
    stage_sequencer_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_d != state_q),
        .cnt_en ((state_q == S_IF && !bus.imem_ready) || (state_q == S_MEM && !bus.dmem_ready)),
        .expire (expire)
    );

    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        step_d   = step_q;
        retire_d = retire_q;
        case (state_q)
            S_IDLE: begin
                state_d = (run || step_req) ? S_IF : S_IDLE;
                step_d  = !run && step_req;
            end
            S_IF: begin
                state_d = bus.imem_ready ? S_ID : expire ? S_HALT : S_IF;
                fault_d = (!bus.imem_ready && expire) ? FLT_IMEM_TO : fault_q;
            end
            S_ID: begin
                state_d = bus.illegal_inst ? S_HALT : S_EX;
                fault_d = bus.illegal_inst ? FLT_ILLEGAL : fault_q;
            end
            S_EX: state_d = bus.is_mem_op ? S_MEM : S_WB;
            S_MEM: begin
                state_d = bus.dmem_ready ? S_WB : expire ? S_HALT : S_MEM;
                fault_d = (!bus.dmem_ready && expire) ? FLT_DMEM_TO : fault_q;
            end
            S_WB: begin
                retire_d = retire_q + 1'b1;
                state_d  = (run && !step_q) ? S_IF : S_IDLE;
                step_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk)
        if (rst) begin
            state_q  <= S_IDLE;
            fault_q  <= FLT_NONE;
            step_q   <= 1'b0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            fault_q  <= fault_d;
            step_q   <= step_d;
            retire_q <= retire_d;
        end

    assign bus.en_if  = state_q == S_IF;
    assign bus.en_id  = state_q == S_ID;
    assign bus.en_ex  = state_q == S_EX;
    assign bus.en_mem = state_q == S_MEM;
    assign bus.en_wb  = state_q == S_WB;
    assign bus.pc_we  = state_q == S_WB;
    assign state      = state_q;
    assign halted     = state_q == S_HALT;
    assign fault_code = fault_q;
    assign retire_cnt = retire_q;
endmodule
